// File: rtl/window_gen_if.sv
// Valid/ready stream interface used for both the pixel input and the chunk output.
interface axis_if #(
    parameter int DW = 24
);
    logic [DW-1:0] data;
    logic          vld;
    logic          rdy;

    modport master (output data, output vld, input rdy);
    modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/window_gen.sv
// Sliding DIM x DIM window generator: cascaded line buffers feed a shift window,
// and only windows fully inside the frame are registered to the output stream.
package pixel_pkg;
    typedef struct packed {
        logic [7:0] red;
        logic [7:0] grn;
        logic [7:0] blu;
    } pixel_t;
endpackage

module window_gen_lbuf #(
    parameter int WIDTH = 640,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  pixel_pkg::pixel_t din,
    output pixel_pkg::pixel_t dout
);
    pixel_pkg::pixel_t mem [WIDTH];

    // Asynchronous read returns the pixel one line older than the one being written.
    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end
endmodule

module window_gen
    import pixel_pkg::*;
#(
    parameter int DIM    = 3,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic  clk,
    input  logic  rst,
    axis_if.slave  axis_i,
    axis_if.master axis_o,
    output logic  frame_done
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    typedef pixel_t [DIM-1:0][DIM-1:0] chunk_t;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    chunk_t        win, win_nxt, out_data;
    logic          out_vld;
    pixel_t        px_in;
    pixel_t        lb_in  [DIM-1];
    pixel_t        lb_out [DIM-1];
    pixel_t        new_col [DIM];
    logic          accept, emit, last_col, last_row;

    assign px_in      = pixel_t'(axis_i.data);
    assign axis_i.rdy = !out_vld || axis_o.rdy;
    assign axis_o.vld = out_vld;
    assign axis_o.data = out_data;

    assign accept   = axis_i.vld && axis_i.rdy;
    assign last_col = (col == CW'(WIDTH - 1));
    assign last_row = (row == RW'(HEIGHT - 1));
    assign emit     = accept && (row >= RW'(DIM - 1)) && (col >= CW'(DIM - 1));

    // Buffer 0 holds the previous line; each buffer passes its evicted pixel down the cascade.
    for (genvar k = 0; k < DIM - 1; k++) begin : g_lbuf
        if (k == 0) begin : g_head
            assign lb_in[k] = px_in;
        end else begin : g_tail
            assign lb_in[k] = lb_out[k-1];
        end
        window_gen_lbuf #(.WIDTH(WIDTH), .AW(CW)) u_lbuf (
            .clk  (clk),
            .we   (accept),
            .addr (col),
            .din  (lb_in[k]),
            .dout (lb_out[k])
        );
        assign new_col[DIM-2-k] = lb_out[k];
    end
    assign new_col[DIM-1] = px_in;

    always_comb begin
        win_nxt = win;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM - 1; j++) win_nxt[i][j] = win[i][j+1];
            win_nxt[i][DIM-1] = new_col[i];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) win <= win_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            out_vld    <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && last_col && last_row;
            if (accept) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) row <= last_row ? '0 : row + 1'b1;
            end
            // A fresh chunk wins over the drain of the previous one.
            if (emit) begin
                out_vld  <= 1'b1;
                out_data <= win_nxt;
            end else if (axis_o.rdy) begin
                out_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen on a 5x4 frame with a 3x3 window.
module tb_window_gen;
    import pixel_pkg::*;

    localparam int DIM = 3, WIDTH = 5, HEIGHT = 4;
    localparam int CDW = 24 * DIM * DIM;
    typedef pixel_t [DIM-1:0][DIM-1:0] chunk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_done;

    axis_if #(.DW(24))  in_if ();
    axis_if #(.DW(CDW)) out_if ();

    window_gen #(.DIM(DIM), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk        (clk),
        .rst        (rst),
        .axis_i     (in_if),
        .axis_o     (out_if),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int fd_cnt = 0;
    int fd_acc = 0;
    bit bp_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [CDW-1:0] prev_data;
    logic [CDW-1:0] q [$];
    int qa [$];

    function automatic pixel_t pix(input int r, input int c, input int off);
        pixel_t p;
        p.red = 8'(r);
        p.grn = 8'(c);
        p.blu = 8'(5 * r + c + off);
        return p;
    endfunction

    // Window whose bottom-right pixel is (r,c).
    function automatic logic [CDW-1:0] exp_chunk(input int r, input int c, input int off);
        chunk_t w;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                w[i][j] = pix(r - (DIM - 1) + i, c - (DIM - 1) + j, off);
        return w;
    endfunction

    // Output ready: random when backpressure is enabled, otherwise always ready.
    always @(posedge clk) begin
        #1;
        out_if.rdy = bp_en ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    // Monitor: collects output transfers, checks hold-while-stalled and the input-ready rule.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (out_if.data !== prev_data) begin
                    $display("FAIL hold_stable got=%h want=%h", out_if.data, prev_data);
                    errors++;
                end
            end
            checks++;
            if (in_if.rdy !== (!out_if.vld || out_if.rdy)) begin
                $display("FAIL in_rdy got=%b want=%b", in_if.rdy, (!out_if.vld || out_if.rdy));
                errors++;
            end
            if (out_if.vld && out_if.rdy) begin
                q.push_back(out_if.data);
                qa.push_back(acc_cnt);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_acc = acc_cnt;
            end
            prev_stall = out_if.vld && !out_if.rdy;
            prev_data  = out_if.data;
        end
    end

    task automatic clear_mon();
        q.delete();
        qa.delete();
        fd_cnt  = 0;
        acc_cnt = 0;
    endtask

    task automatic send_pix(input pixel_t px, input bit gaps);
        int n;
        bit done, acc;
        n = 0;
        done = 1'b0;
        while (!done) begin
            if (gaps && $urandom_range(1, 0) == 1) begin
                in_if.vld = 1'b0;
            end else begin
                in_if.vld  = 1'b1;
                in_if.data = px;
            end
            @(negedge clk);
            acc = in_if.vld && in_if.rdy;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1'b1;
                acc_cnt++;
            end
            n++;
            if (!done && n > 200) begin
                $display("FAIL send_timeout got=stalled want=accepted");
                errors++;
                done = 1'b1;
            end
        end
        in_if.vld = 1'b0;
    endtask

    task automatic feed_frame(input int off, input bit gaps);
        for (int r = 0; r < HEIGHT; r++)
            for (int c = 0; c < WIDTH; c++)
                send_pix(pix(r, c, off), gaps);
    endtask

    task automatic drain();
        int n;
        bp_en = 1'b0;
        n = 0;
        repeat (2) @(posedge clk);
        #1;
        while (out_if.vld === 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (out_if.vld !== 1'b0) begin
            $display("FAIL drain_timeout got=%b want=0", out_if.vld);
            errors++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_if.vld  = 1'b0;
        in_if.data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_if.vld !== 1'b0) begin $display("FAIL reset_vld got=%b want=0", out_if.vld); errors++; end
        checks++;
        if (out_if.data !== '0) begin $display("FAIL reset_data got=%h want=0", out_if.data); errors++; end
        checks++;
        if (frame_done !== 1'b0) begin $display("FAIL reset_fd got=%b want=0", frame_done); errors++; end
        checks++;
        if (in_if.rdy !== 1'b1) begin $display("FAIL reset_in_rdy got=%b want=1", in_if.rdy); errors++; end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic test_basic();
        clear_mon();
        feed_frame(0, 1'b0);
        drain();
        checks++;
        if (q.size() != 6) begin $display("FAIL basic_count got=%0d want=6", q.size()); errors++; end
        for (int k = 0; k < 6 && k < q.size(); k++) begin
            checks++;
            if (q[k] !== exp_chunk(2 + k / 3, 2 + k % 3, 0)) begin
                $display("FAIL basic_chunk%0d got=%h want=%h", k, q[k], exp_chunk(2 + k / 3, 2 + k % 3, 0));
                errors++;
            end
        end
        checks++;
        if (qa.size() > 0 && qa[0] != 13) begin $display("FAIL basic_first_latency got=%0d want=13", qa[0]); errors++; end
        checks++;
        if (fd_cnt != 1 || fd_acc != 20) begin
            $display("FAIL basic_frame_done got=%0d@%0d want=1@20", fd_cnt, fd_acc);
            errors++;
        end
    endtask

    task automatic test_backpressure();
        clear_mon();
        bp_en = 1'b1;
        feed_frame(0, 1'b0);
        drain();
        checks++;
        if (q.size() != 6) begin $display("FAIL bp_count got=%0d want=6", q.size()); errors++; end
        for (int k = 0; k < 6 && k < q.size(); k++) begin
            checks++;
            if (q[k] !== exp_chunk(2 + k / 3, 2 + k % 3, 0)) begin
                $display("FAIL bp_chunk%0d got=%h want=%h", k, q[k], exp_chunk(2 + k / 3, 2 + k % 3, 0));
                errors++;
            end
        end
        checks++;
        if (fd_cnt != 1) begin $display("FAIL bp_frame_done got=%0d want=1", fd_cnt); errors++; end
    endtask

    task automatic test_gaps();
        clear_mon();
        feed_frame(0, 1'b1);
        drain();
        checks++;
        if (q.size() != 6) begin $display("FAIL gaps_count got=%0d want=6", q.size()); errors++; end
        for (int k = 0; k < 6 && k < q.size(); k++) begin
            checks++;
            if (q[k] !== exp_chunk(2 + k / 3, 2 + k % 3, 0)) begin
                $display("FAIL gaps_chunk%0d got=%h want=%h", k, q[k], exp_chunk(2 + k / 3, 2 + k % 3, 0));
                errors++;
            end
        end
    endtask

    task automatic test_back_to_back();
        chunk_t ch;
        clear_mon();
        feed_frame(0, 1'b0);
        feed_frame(100, 1'b0);
        drain();
        checks++;
        if (q.size() != 12) begin $display("FAIL b2b_count got=%0d want=12", q.size()); errors++; end
        for (int k = 0; k < 12 && k < q.size(); k++) begin
            checks++;
            if (q[k] !== exp_chunk(2 + (k % 6) / 3, 2 + k % 3, (k / 6) * 100)) begin
                $display("FAIL b2b_chunk%0d got=%h want=%h", k, q[k],
                         exp_chunk(2 + (k % 6) / 3, 2 + k % 3, (k / 6) * 100));
                errors++;
            end
        end
        if (q.size() > 6) begin
            ch = q[6];
            checks++;
            if (ch[0][0].blu !== 8'd100) begin $display("FAIL b2b_f2_origin got=%0d want=100", ch[0][0].blu); errors++; end
        end
        checks++;
        if (fd_cnt != 2) begin $display("FAIL b2b_frame_done got=%0d want=2", fd_cnt); errors++; end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        for (int i = 0; i < 8; i++) send_pix(pix(i / WIDTH, i % WIDTH, 50), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_if.vld !== 1'b0) begin $display("FAIL midrst_vld got=%b want=0", out_if.vld); errors++; end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        feed_frame(0, 1'b0);
        drain();
        checks++;
        if (q.size() != 6) begin $display("FAIL midrst_count got=%0d want=6", q.size()); errors++; end
        for (int k = 0; k < 6 && k < q.size(); k++) begin
            checks++;
            if (q[k] !== exp_chunk(2 + k / 3, 2 + k % 3, 0)) begin
                $display("FAIL midrst_chunk%0d got=%h want=%h", k, q[k], exp_chunk(2 + k / 3, 2 + k % 3, 0));
                errors++;
            end
        end
        checks++;
        if (fd_cnt != 1) begin $display("FAIL midrst_frame_done got=%0d want=1", fd_cnt); errors++; end
    endtask

    task automatic test_line_boundary();
        chunk_t ch;
        clear_mon();
        feed_frame(0, 1'b0);
        drain();
        checks++;
        if (qa.size() < 4 || qa[2] != 15 || qa[3] != 18) begin
            $display("FAIL lb_timing got=%0d,%0d want=15,18",
                     qa.size() > 2 ? qa[2] : -1, qa.size() > 3 ? qa[3] : -1);
            errors++;
        end
        if (q.size() > 3) begin
            ch = q[3];
            for (int j = 0; j < DIM; j++) begin
                checks++;
                if (ch[2][j] !== pix(3, j, 0)) begin
                    $display("FAIL lb_bottom%0d got=%h want=%h", j, ch[2][j], pix(3, j, 0));
                    errors++;
                end
                checks++;
                if (ch[0][j] !== pix(1, j, 0)) begin
                    $display("FAIL lb_top%0d got=%h want=%h", j, ch[0][j], pix(1, j, 0));
                    errors++;
                end
            end
        end
    endtask

    initial begin
        out_if.rdy = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_back_to_back();
        test_reset_midframe();
        test_line_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_gen.md
Name: window_gen

Overview:
- Streaming sliding-window generator that sits directly upstream of the convolution stage.
- Accepts a raster-order pixel stream (one pixel_pkg::pixel_t per transfer) and builds DIM-row line buffers.
- Emits one DIM x DIM pixel chunk per input pixel whose window lies fully inside the frame.
- Border positions are consumed without output, so each frame yields (HEIGHT-DIM+1)*(WIDTH-DIM+1) chunks.

Parameters:
- DIM, 3, window edge length (odd, >= 3)
- WIDTH, 640, pixels per line (> DIM)
- HEIGHT, 480, lines per frame (>= DIM)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- axis_i  axis_if.slave  data = pixel_t (24: red, grn, blu 8 each) + vld/rdy  input pixel stream, raster order
- axis_o  axis_if.master  data = pixel_t [DIM][DIM] (24*DIM*DIM) + vld/rdy  output chunk stream
- frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Transfer occurs when vld & rdy (axis ok) in the same cycle. Data is held stable while vld=1 and rdy=0.
- Reset values: axis_o.vld=0, axis_o.data=0, frame_done=0, col=0, row=0. Line-buffer and shift-register contents need not be cleared.
- Reset mid-frame discards the partial frame. The next accepted pixel is (0,0).
- Counters:
  - col counts 0..WIDTH-1.
  - row increments when col wraps and counts 0..HEIGHT-1.
  - Both wrap to 0 after pixel (HEIGHT-1, WIDTH-1).
  - frame_done=1 in the cycle after that pixel is accepted.
- Storage:
  - DIM-1 line buffers of WIDTH pixels, one write per accepted pixel at address col.
  - A DIM x DIM shift window. On each accept every row shifts left one column.
  - The new right column is {linebuf[DIM-2][col] .. linebuf[0][col], input pixel}, oldest row first.
  - Line buffers cascade: a pixel leaving buffer k is written into buffer k+1.
- Chunk indexing: data[i][j], i=0 is the oldest row (top), j=0 the oldest column (left). data[DIM-1][DIM-1] is the just-accepted pixel, and data[DIM/2][DIM/2] is the centre.
- Emission:
  - On accepting pixel (r,c) with r >= DIM-1 and c >= DIM-1, the updated window is registered to axis_o.data and axis_o.vld=1 on the next cycle. Latency is 1 cycle.
  - Windows never straddle lines: windows at c < DIM-1 are suppressed even though the shift register holds stale columns.
- Backpressure: axis_i.rdy = !axis_o.vld | axis_o.rdy (single output register).
  - axis_o.vld clears after an output transfer unless a new chunk is loaded in the same cycle.
  - Simultaneous output transfer and new emitting accept: the new chunk is loaded and vld stays 1.
- Non-emitting accepts (border pixels) still require rdy. Counters and buffers advance only on accept.
- No input is dropped or duplicated under any vld/rdy pattern.
- Arithmetic: counters are $clog2(WIDTH) and $clog2(HEIGHT) bits, compared with ==, no overflow beyond the wrap.

Test Plan:
1. DIM=3, WIDTH=5, HEIGHT=4, p(r,c) = {red=r, grn=c, blu=5r+c}, continuous vld, axis_o.rdy=1 -> exactly 6 chunks; the first appears 1 cycle after accepting p(2,2) (13th pixel); data[0][0]=p(0,0), data[1][1]=p(1,1), data[2][2]=p(2,2); the last chunk has data[0][0]=p(1,2), data[2][2]=p(3,4); frame_done pulses once, after p(3,4).
2. Same frame with axis_o.rdy toggling 1,0,0,1 pseudo-randomly -> same 6 chunks in order; axis_o.data stable while vld & !rdy; axis_i.rdy=0 only when vld=1 and rdy=0.
3. Same frame with random input vld gaps (about 50%) -> identical chunk sequence; no emission on idle cycles.
4. Two back-to-back frames with different values (second frame blu += 100) -> 12 chunks; the first chunk of frame 2 contains only frame-2 pixels (data[0][0].blu=100); frame_done pulses twice.
5. Assert rst after 8 accepted pixels, then send a full frame -> axis_o.vld=0 the cycle after reset; output equals scenario 1 exactly (no stale-frame chunks).
6. Line-boundary check, WIDTH=5: accept p(3,0) and p(3,1) -> no chunk produced; p(3,2) -> chunk with data[2][0..2] = p(3,0..2) and data[0][0..2] = p(1,0..2).
